// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the 16-entry reorder buffer.
// Optional build macro used by the top: ROB_CDB_FWD_EN (same-cycle CDB forwarding on query ports).
package rob_pkg;

    localparam int ROB_AW    = 4;
    localparam int ROB_DEPTH = 1 << ROB_AW;

    localparam logic [1:0] ROB_REG    = 2'd0;
    localparam logic [1:0] ROB_BRANCH = 2'd1;
    localparam logic [1:0] ROB_STORE  = 2'd2;
    localparam logic [1:0] ROB_JUMP   = 2'd3;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred_taken;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

    function automatic logic [ROB_AW-1:0] rob_ptr_inc(input logic [ROB_AW-1:0] ptr);
        return ptr + ROB_AW'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder / CDB / commit bundle of the reorder buffer.
// master = decoder-side driver, slave = the reorder buffer itself.
interface reorder_buffer_if;
    import rob_pkg::*;

    logic              alloc_valid;
    logic [1:0]        alloc_type;
    logic [4:0]        alloc_rd;
    logic              alloc_pred_taken;
    logic [ROB_AW-1:0] alloc_id;
    logic              rob_full;

    logic              cdb_valid;
    logic [ROB_AW-1:0] cdb_id;
    logic [31:0]       cdb_val;
    logic              cdb_taken;
    logic [31:0]       cdb_target;

    logic [ROB_AW-1:0] q1_id;
    logic [ROB_AW-1:0] q2_id;
    logic              q1_ready;
    logic              q2_ready;
    logic [31:0]       q1_val;
    logic [31:0]       q2_val;

    logic              commit_config;
    logic [4:0]        rs_to_write_id;
    logic [31:0]       rs_to_write_val;
    logic [ROB_AW-1:0] commit_rob_id;
    logic              store_commit;
    logic              rollback_config;
    logic [31:0]       rollback_pc;

    modport master (
        output alloc_valid, alloc_type, alloc_rd, alloc_pred_taken,
        output cdb_valid, cdb_id, cdb_val, cdb_taken, cdb_target,
        output q1_id, q2_id,
        input  alloc_id, rob_full, q1_ready, q2_ready, q1_val, q2_val,
        input  commit_config, rs_to_write_id, rs_to_write_val, commit_rob_id,
        input  store_commit, rollback_config, rollback_pc
    );

    modport slave (
        input  alloc_valid, alloc_type, alloc_rd, alloc_pred_taken,
        input  cdb_valid, cdb_id, cdb_val, cdb_taken, cdb_target,
        input  q1_id, q2_id,
        output alloc_id, rob_full, q1_ready, q2_ready, q1_val, q2_val,
        output commit_config, rs_to_write_id, rs_to_write_val, commit_rob_id,
        output store_commit, rollback_config, rollback_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order retirement, CDB capture and mispredict rollback.
// Define ROB_CDB_FWD_EN to let the operand query ports see a same-cycle CDB broadcast.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    reorder_buffer_if.slave  bus
);

    rob_entry_t        r_rob [ROB_DEPTH];
    logic [ROB_AW-1:0] r_head;
    logic [ROB_AW-1:0] r_tail;
    logic [ROB_AW:0]   r_count;

    rob_entry_t w_head_e;
    rob_entry_t w_new_e;
    logic       w_commit;
    logic       w_alloc;
    logic       w_cdb_hit;
    logic       w_wr_rd;
    logic       w_store;
    logic       w_rollback;

    // Head-entry decode: what retires this cycle and whether it redirects the front end.
    always_comb begin
        w_head_e   = r_rob[r_head];
        w_commit   = rdy & w_head_e.busy & w_head_e.ready;
        w_alloc    = rdy & bus.alloc_valid;
        w_cdb_hit  = rdy & bus.cdb_valid & r_rob[bus.cdb_id].busy;
        w_wr_rd    = 1'b0;
        w_store    = 1'b0;
        w_rollback = 1'b0;
        case (w_head_e.typ)
            ROB_REG:    w_wr_rd = w_commit;
            ROB_BRANCH: w_rollback = w_commit & (w_head_e.taken != w_head_e.pred_taken);
            ROB_STORE:  w_store = w_commit;
            ROB_JUMP: begin
                // Always redirect: covers jalr, whose target is only known at resolve.
                w_wr_rd    = w_commit;
                w_rollback = w_commit;
            end
            default: begin
                w_wr_rd    = 1'b0;
                w_store    = 1'b0;
                w_rollback = 1'b0;
            end
        endcase

        w_new_e            = '0;
        w_new_e.busy       = 1'b1;
        w_new_e.typ        = bus.alloc_type;
        w_new_e.rd         = bus.alloc_rd;
        w_new_e.pred_taken = bus.alloc_pred_taken;
    end

    assign bus.alloc_id        = r_tail;
    assign bus.rob_full        = (r_count >= 5'd15);
    assign bus.commit_config   = w_wr_rd;
    assign bus.rs_to_write_id  = w_wr_rd ? w_head_e.rd : 5'd0;
    assign bus.rs_to_write_val = w_wr_rd ? w_head_e.val : 32'd0;
    assign bus.commit_rob_id   = w_wr_rd ? r_head : 4'd0;
    assign bus.store_commit    = w_store;
    assign bus.rollback_config = w_rollback;
    assign bus.rollback_pc     = w_rollback ? w_head_e.target : 32'd0;

    // Operand lookup, optionally bypassing the CDB of the current cycle.
    always_comb begin
        bus.q1_ready = r_rob[bus.q1_id].ready;
        bus.q1_val   = r_rob[bus.q1_id].val;
        bus.q2_ready = r_rob[bus.q2_id].ready;
        bus.q2_val   = r_rob[bus.q2_id].val;
`ifdef ROB_CDB_FWD_EN
        if (bus.cdb_valid && (bus.cdb_id == bus.q1_id)) begin
            bus.q1_ready = 1'b1;
            bus.q1_val   = bus.cdb_val;
        end else begin
            bus.q1_ready = r_rob[bus.q1_id].ready;
        end
        if (bus.cdb_valid && (bus.cdb_id == bus.q2_id)) begin
            bus.q2_ready = 1'b1;
            bus.q2_val   = bus.cdb_val;
        end else begin
            bus.q2_ready = r_rob[bus.q2_id].ready;
        end
`else
        bus.q1_ready = r_rob[bus.q1_id].ready;
        bus.q2_ready = r_rob[bus.q2_id].ready;
`endif
    end

    // Entry storage, pointers and occupancy; rollback discards same-cycle alloc/CDB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_rob[i] <= '0;
            end
            r_head  <= 4'd0;
            r_tail  <= 4'd0;
            r_count <= 5'd0;
        end else if (rdy) begin
            if (w_rollback) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_rob[i].busy  <= 1'b0;
                    r_rob[i].ready <= 1'b0;
                end
                r_head  <= 4'd0;
                r_tail  <= 4'd0;
                r_count <= 5'd0;
            end else begin
                if (w_cdb_hit) begin
                    r_rob[bus.cdb_id].ready  <= 1'b1;
                    r_rob[bus.cdb_id].val    <= bus.cdb_val;
                    r_rob[bus.cdb_id].taken  <= bus.cdb_taken;
                    r_rob[bus.cdb_id].target <= bus.cdb_target;
                end
                if (w_commit) begin
                    r_rob[r_head].busy  <= 1'b0;
                    r_rob[r_head].ready <= 1'b0;
                    r_head              <= rob_ptr_inc(r_head);
                end
                if (w_alloc) begin
                    r_rob[r_tail] <= w_new_e;
                    r_tail        <= rob_ptr_inc(r_tail);
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + 5'd1;
                    2'b01:   r_count <= r_count - 5'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (expectations hand-computed).
module tb_reorder_buffer;

    logic clk;
    logic rst_n;
    logic rdy;

    int n_cmp;
    int n_err;

    reorder_buffer_if u_if ();

    reorder_buffer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        u_if.alloc_valid      = 1'b0;
        u_if.alloc_type       = 2'd0;
        u_if.alloc_rd         = 5'd0;
        u_if.alloc_pred_taken = 1'b0;
        u_if.cdb_valid        = 1'b0;
        u_if.cdb_id           = 4'd0;
        u_if.cdb_val          = 32'd0;
        u_if.cdb_taken        = 1'b0;
        u_if.cdb_target       = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] typ, input logic [4:0] rd, input logic pt);
        u_if.alloc_valid      = 1'b1;
        u_if.alloc_type       = typ;
        u_if.alloc_rd         = rd;
        u_if.alloc_pred_taken = pt;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        u_if.cdb_valid  = 1'b1;
        u_if.cdb_id     = id;
        u_if.cdb_val    = v;
        u_if.cdb_taken  = tk;
        u_if.cdb_target = tg;
    endtask

    initial begin
        logic fwd;
`ifdef ROB_CDB_FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        n_cmp = 0;
        n_err = 0;
        rdy = 1'b1;
        u_if.q1_id = 4'd0;
        u_if.q2_id = 4'd0;
        do_reset();

        // reset state
        chk("rst_alloc_id", 32'(u_if.alloc_id), 32'd0);
        chk("rst_full", 32'(u_if.rob_full), 32'd0);
        chk("rst_commit", 32'(u_if.commit_config), 32'd0);
        chk("rst_rollback", 32'(u_if.rollback_config), 32'd0);
        chk("rst_store", 32'(u_if.store_commit), 32'd0);
        chk("rst_q1_ready", 32'(u_if.q1_ready), 32'd0);
        chk("rst_q1_val", u_if.q1_val, 32'd0);

        // single REG allocate / writeback / commit
        alloc(2'd0, 5'd5, 1'b0);
        chk("t1_alloc_id", 32'(u_if.alloc_id), 32'd0);
        tick();
        idle();
        cdb(4'd0, 32'h1234, 1'b0, 32'd0);
        #1;
        chk("t1_q1_fwd", 32'(u_if.q1_ready), 32'(fwd));
        chk("t1_no_commit_same_cyc", 32'(u_if.commit_config), 32'd0);
        tick();
        idle();
        #1;
        chk("t1_commit", 32'(u_if.commit_config), 32'd1);
        chk("t1_rd", 32'(u_if.rs_to_write_id), 32'd5);
        chk("t1_val", u_if.rs_to_write_val, 32'h1234);
        chk("t1_rob_id", 32'(u_if.commit_rob_id), 32'd0);
        chk("t1_q1_ready", 32'(u_if.q1_ready), 32'd1);
        chk("t1_q1_val", u_if.q1_val, 32'h1234);
        tick();
        chk("t1_commit_done", 32'(u_if.commit_config), 32'd0);
        chk("t1_alloc_id_next", 32'(u_if.alloc_id), 32'd1);

        // out-of-order writeback, in-order commit
        do_reset();
        alloc(2'd0, 5'd1, 1'b0);
        tick();
        alloc(2'd0, 5'd2, 1'b0);
        chk("t2_alloc_id1", 32'(u_if.alloc_id), 32'd1);
        tick();
        idle();
        cdb(4'd1, 32'hB, 1'b0, 32'd0);
        tick();
        idle();
        #1;
        chk("t2_hold_head", 32'(u_if.commit_config), 32'd0);
        cdb(4'd0, 32'hA, 1'b0, 32'd0);
        tick();
        idle();
        #1;
        chk("t2_c0", 32'(u_if.commit_config), 32'd1);
        chk("t2_c0_rd", 32'(u_if.rs_to_write_id), 32'd1);
        chk("t2_c0_val", u_if.rs_to_write_val, 32'hA);
        chk("t2_c0_id", 32'(u_if.commit_rob_id), 32'd0);
        tick();
        chk("t2_c1", 32'(u_if.commit_config), 32'd1);
        chk("t2_c1_rd", 32'(u_if.rs_to_write_id), 32'd2);
        chk("t2_c1_val", u_if.rs_to_write_val, 32'hB);
        chk("t2_c1_id", 32'(u_if.commit_rob_id), 32'd1);
        tick();
        chk("t2_empty", 32'(u_if.commit_config), 32'd0);

        // fill to 15, commit+alloc keeps count, tail wraps
        do_reset();
        for (int i = 0; i < 15; i++) begin
            alloc(2'd0, 5'(i), 1'b0);
            tick();
        end
        idle();
        #1;
        chk("t3_full", 32'(u_if.rob_full), 32'd1);
        chk("t3_tail15", 32'(u_if.alloc_id), 32'd15);
        cdb(4'd0, 32'h55, 1'b0, 32'd0);
        tick();
        idle();
        alloc(2'd0, 5'd20, 1'b0);
        #1;
        chk("t3_commit", 32'(u_if.commit_config), 32'd1);
        chk("t3_commit_val", u_if.rs_to_write_val, 32'h55);
        tick();
        idle();
        #1;
        chk("t3_still_full", 32'(u_if.rob_full), 32'd1);
        chk("t3_tail_wrap", 32'(u_if.alloc_id), 32'd0);
        chk("t3_no_commit", 32'(u_if.commit_config), 32'd0);

        // mispredicted BRANCH rollback discards same-cycle allocate
        do_reset();
        alloc(2'd1, 5'd0, 1'b0);
        tick();
        alloc(2'd0, 5'd3, 1'b0);
        tick();
        idle();
        cdb(4'd0, 32'd0, 1'b1, 32'h100);
        tick();
        idle();
        alloc(2'd0, 5'd6, 1'b0);
        u_if.q2_id = 4'd1;
        #1;
        chk("t4_rollback", 32'(u_if.rollback_config), 32'd1);
        chk("t4_rollback_pc", u_if.rollback_pc, 32'h100);
        chk("t4_br_no_write", 32'(u_if.commit_config), 32'd0);
        tick();
        idle();
        #1;
        chk("t4_rollback_1cyc", 32'(u_if.rollback_config), 32'd0);
        chk("t4_alloc_id0", 32'(u_if.alloc_id), 32'd0);
        chk("t4_not_full", 32'(u_if.rob_full), 32'd0);
        chk("t4_q2_flushed", 32'(u_if.q2_ready), 32'd0);
        alloc(2'd0, 5'd7, 1'b0);
        tick();
        idle();
        cdb(4'd0, 32'h77, 1'b0, 32'd0);
        tick();
        idle();
        #1;
        chk("t4_post_rb_rd", 32'(u_if.rs_to_write_id), 32'd7);
        chk("t4_post_rb_id", 32'(u_if.commit_rob_id), 32'd0);
        tick();

        // JUMP: writes rd and always redirects
        alloc(2'd3, 5'd9, 1'b1);
        chk("t5_jump_id", 32'(u_if.alloc_id), 32'd1);
        tick();
        idle();
        cdb(4'd1, 32'h44, 1'b1, 32'h200);
        tick();
        idle();
        #1;
        chk("t5_commit", 32'(u_if.commit_config), 32'd1);
        chk("t5_rd", 32'(u_if.rs_to_write_id), 32'd9);
        chk("t5_val", u_if.rs_to_write_val, 32'h44);
        chk("t5_rob_id", 32'(u_if.commit_rob_id), 32'd1);
        chk("t5_rollback", 32'(u_if.rollback_config), 32'd1);
        chk("t5_pc", u_if.rollback_pc, 32'h200);
        tick();
        chk("t5_alloc_id0", 32'(u_if.alloc_id), 32'd0);

        // STORE commit, then correctly predicted BRANCH
        alloc(2'd2, 5'd0, 1'b0);
        tick();
        alloc(2'd1, 5'd0, 1'b1);
        tick();
        idle();
        cdb(4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        idle();
        cdb(4'd1, 32'd0, 1'b1, 32'h300);
        #1;
        chk("t6_store", 32'(u_if.store_commit), 32'd1);
        chk("t6_store_no_write", 32'(u_if.commit_config), 32'd0);
        chk("t6_store_no_rb", 32'(u_if.rollback_config), 32'd0);
        tick();
        idle();
        #1;
        chk("t6_br_store", 32'(u_if.store_commit), 32'd0);
        chk("t6_br_no_write", 32'(u_if.commit_config), 32'd0);
        chk("t6_br_no_rb", 32'(u_if.rollback_config), 32'd0);
        tick();

        // rdy low freezes commit and allocation
        alloc(2'd0, 5'd4, 1'b0);
        chk("t7_alloc_id2", 32'(u_if.alloc_id), 32'd2);
        tick();
        idle();
        cdb(4'd2, 32'h9, 1'b0, 32'd0);
        tick();
        idle();
        rdy = 1'b0;
        alloc(2'd0, 5'd11, 1'b0);
        #1;
        chk("t7_stall_commit", 32'(u_if.commit_config), 32'd0);
        tick();
        tick();
        rdy = 1'b1;
        idle();
        #1;
        chk("t7_frozen_tail", 32'(u_if.alloc_id), 32'd3);
        chk("t7_resume", 32'(u_if.commit_config), 32'd1);
        chk("t7_rd", 32'(u_if.rs_to_write_id), 32'd4);
        chk("t7_val", u_if.rs_to_write_val, 32'h9);
        chk("t7_rob_id", 32'(u_if.commit_rob_id), 32'd2);
        tick();
        chk("t7_done", 32'(u_if.commit_config), 32'd0);

        // CDB to a non-busy entry is ignored
        cdb(4'd5, 32'hDEAD, 1'b0, 32'd0);
        tick();
        idle();
        u_if.q1_id = 4'd5;
        #1;
        chk("t8_nonbusy_ready", 32'(u_if.q1_ready), 32'd0);
        chk("t8_nonbusy_val", u_if.q1_val, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- 16-entry circular reorder buffer between the decoder/issue stage and the architectural register file.
- Allocates one entry per decoded instruction and returns its 4-bit ROB id; the decoder uses that id to tag the destination register.
- Captures results from the common data bus (CDB) and retires entries strictly in order.
- Drives the register-file commit port and the global rollback signal when a branch at the head was mispredicted.

## Interface
- `ROB_AW`, default 4: log2 of the entry count. Must stay 4 so ids match the register file's 4-bit tags.
- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rdy` in 1: global enable. When low, all state holds and `commit_config`/`rollback_config` are 0.
- `alloc_valid` in 1: the decoder requests an entry this cycle.
- `alloc_type` in 2: 0 = REG (writes rd), 1 = BRANCH, 2 = STORE, 3 = JUMP (writes rd and can redirect).
- `alloc_rd` in 5: destination register.
- `alloc_pred_taken` in 1: predictor decision for BRANCH/JUMP.
- `alloc_id` out 4: equals the tail pointer; valid whenever `rob_full` = 0.
- `rob_full` out 1: count ≥ 15. The decoder must not assert `alloc_valid` while this is high.
- `cdb_valid` in 1, `cdb_id` in 4, `cdb_val` in 32: result broadcast.
- `cdb_taken` in 1, `cdb_target` in 32: resolved direction and target for BRANCH/JUMP.
- `q1_id`, `q2_id` in 4: operand lookups from the decoder.
- `q1_ready`, `q2_ready` out 1; `q1_val`, `q2_val` out 32: ready flag and value of the queried entry.
- `commit_config` out 1, `rs_to_write_id` out 5, `rs_to_write_val` out 32, `commit_rob_id` out 4: register-file write port.
- `store_commit` out 1: the head STORE retires this cycle (tells the load/store buffer to perform it).
- `rollback_config` out 1, `rollback_pc` out 32: flush and redirect.

## Operation
Per-entry state:
- `busy`, `ready`, `type`, `rd`, `val`, `pred_taken`, `taken`, `target`.
- Plus `head`, `tail` (4 bits each, wrap 15→0) and `count` (5 bits).

Allocation:
- Takes effect when `alloc_valid & rdy`.
- Entry[tail] gets `busy=1`, `ready=0` and the alloc fields; `tail++`.

Writeback:
- When `cdb_valid & rdy & busy[cdb_id]`: entry gets `ready=1`, `val`, `taken`, `target`.
- A CDB hit on a non-busy entry is ignored.

Commit:
- Fires when `busy[head] & ready[head] & rdy`. Outputs are combinational from the head entry.
- REG/JUMP: `commit_config=1`, `rs_to_write_id=rd`, `rs_to_write_val=val`, `commit_rob_id=head`.
- STORE: `store_commit=1`, `commit_config=0`.
- BRANCH: no register write.
- BRANCH/JUMP with `taken != pred_taken`, or JUMP always (covers jalr): `rollback_config=1`, `rollback_pc=target`.
  - The JUMP's own rd write still commits in the same cycle.
- `head++` on every commit.

Rollback:
- At the same posedge, clear every `busy`, set `head=tail=count=0`.
- Allocation and CDB writes in that cycle are discarded.

Count:
- Allocate only: +1. Commit only: −1. Both in the same cycle: unchanged.

Operand query (combinational):
- `qN_ready = ready[qN_id]`, `qN_val = val[qN_id]`.

Reset:
- Sampled `rst_n=0` clears every `busy`/`ready` and sets `head=tail=count=0`.
- Reset has priority over `rdy` and over any in-flight event.
- All outputs read 0 after reset, including `alloc_id=0` and `rob_full=0`.

## Timing
- `alloc_id` is valid in the same cycle as `alloc_valid`; the entry exists from the next cycle.
- A CDB write in cycle N makes `qN_ready` visible and the entry committable in cycle N+1.
- At most one commit per cycle.
- An entry written in cycle N commits in cycle N+1 at the earliest if it is at the head.
- `rollback_config` lasts exactly one cycle.
- The first allocation after rollback is in cycle N+1 and receives id 0.
- `rob_full` is registered-count based: it asserts at count 15, giving the decoder one cycle of slack.
- Simultaneous allocate, CDB write and commit on distinct entries all take effect.
- CDB write to the head entry in the same cycle it is examined: no commit that cycle.

## Configuration
- `ROB_CDB_FWD_EN`: when defined, the query ports also match a same-cycle CDB broadcast.
  - If `cdb_valid & cdb_id==qN_id`, then `qN_ready=1` and `qN_val=cdb_val`.
- Without the macro: pure array read, so CDB results become visible one cycle later.

## Structure
- Shared package `rob_pkg`:
  - `ROB_AW`.
  - Entry-type constants `ROB_REG`, `ROB_BRANCH`, `ROB_STORE`, `ROB_JUMP`.
  - Packed entry struct `rob_entry_t`.
- No sub-module: storage, pointers and commit logic live in `reorder_buffer`.

## Test plan
- Reset, then allocate REG rd=5 (id 0); CDB id 0 val 0x1234 → next cycle `commit_config=1`, `rs_to_write_id=5`, `rs_to_write_val=0x1234`, `commit_rob_id=0`.
- Allocate ids 0,1; CDB writes id 1 before id 0 → no commit until id 0 is ready, then commits in cycles 0 then 1 (in order).
- Allocate 15 entries → `rob_full=1`; one commit with a simultaneous allocate → count stays 15; tail wraps 15→0 after 16 allocations.
- BRANCH `pred_taken=0`, CDB `taken=1` `target=0x100` → `rollback_config=1`, `rollback_pc=0x100` for one cycle; next cycle count=0 and `alloc_id=0`.
- `rdy=0` while the head is ready → no commit, pointers frozen; `rdy=1` → commit resumes.
- With `ROB_CDB_FWD_EN`: `q1_id=3` and CDB id 3 val 7 in the same cycle → `q1_ready=1`, `q1_val=7`. Without it: `q1_ready=0` that cycle.
